// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions for the vertical and horizontal engines.
// Contents: frame phase enum, default 640x480 vertical timing constants,
// and small width/ceiling helpers used to size counters from parameters.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_SYNC        = 2'd0,
    PH_BACK_PORCH  = 2'd1,
    PH_ACTIVE      = 2'd2,
    PH_FRONT_PORCH = 2'd3
  } phase_e;

  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_SCALE    = 5;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned min_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/scale_counter.sv
// Scaled-row counter: groups SCALE display lines into one output row.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : restart at row 0 (entering the active window); pulses row_start
//   step        : one completed active line that stays inside the window
//   row         : current scaled row, 0..ROWS-1, saturating at ROWS-1
//   row_start   : registered one-cycle pulse whenever row takes a new value
import vga_timing_pkg::*;

module scale_counter #(
  parameter  int unsigned SCALE = DEF_SCALE,
  parameter  int unsigned ROWS  = ceil_div(DEF_V_ACTIVE, DEF_SCALE),
  localparam int unsigned SCL_W = min_width(ROWS),
  localparam int unsigned SUB_W = min_width(SCALE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  output logic [SCL_W-1:0] row,
  output logic             row_start
);

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);
  localparam logic [SCL_W-1:0] ROW_LAST = SCL_W'(ROWS - 1);

  logic [SUB_W-1:0] sub;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub       <= '0;
      row       <= '0;
      row_start <= 1'b0;
    end else begin
      row_start <= 1'b0;
      if (clear) begin
        sub       <= '0;
        row       <= '0;
        row_start <= 1'b1;
      end else if (step) begin
        if (sub == SUB_LAST) begin
          sub <= '0;
          // A partial last row simply stays at ROWS-1 instead of wrapping.
          if (row != ROW_LAST) begin
            row       <= row + 1'b1;
            row_start <= 1'b1;
          end
        end else begin
          sub <= sub + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vertical_timing_engine.sv
// Vertical timing engine: counts lines from the horizontal generator and
// produces the vertical sync, active window and scaled-row indices.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   new_line     : one-cycle end-of-line pulse from the horizontal engine
//   ver_cnt      : current line, 0..V_TOTAL-1
//   scl_ver_cnt  : scaled active row, 0..ROWS-1 (held at ROWS-1 between windows)
//   VSYNC        : SYNC_POL during sync lines, otherwise inverted
//   v_active     : high on active lines
//   frame_start  : one-cycle pulse when ver_cnt wraps to 0
//   row_start    : one-cycle pulse when scl_ver_cnt takes a new value
// All outputs are registered from next-state values so they change on the
// same edge as ver_cnt.
import vga_timing_pkg::*;

module vertical_timing_engine #(
  parameter  int unsigned V_SYNC   = DEF_V_SYNC,
  parameter  int unsigned V_BP     = DEF_V_BP,
  parameter  int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter  int unsigned V_FP     = DEF_V_FP,
  parameter  int unsigned SCALE    = DEF_SCALE,
  parameter  bit          SYNC_POL = 1'b0,
  localparam int unsigned V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP,
  localparam int unsigned VCNT_W   = $clog2(V_TOTAL),
  localparam int unsigned ROWS     = ceil_div(V_ACTIVE, SCALE),
  localparam int unsigned SCL_W    = min_width(ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_line,
  output logic [VCNT_W-1:0] ver_cnt,
  output logic [SCL_W-1:0]  scl_ver_cnt,
  output logic              VSYNC,
  output logic              v_active,
  output logic              frame_start,
  output logic              row_start
);

  localparam logic [VCNT_W-1:0] VCNT_MAX    = VCNT_W'(V_TOTAL - 1);
  localparam logic [VCNT_W-1:0] SYNC_LAST   = VCNT_W'(V_SYNC - 1);
  localparam logic [VCNT_W-1:0] BP_LAST     = VCNT_W'(V_BP - 1);
  localparam logic [VCNT_W-1:0] ACTIVE_LAST = VCNT_W'(V_ACTIVE - 1);
  localparam logic [VCNT_W-1:0] FP_LAST     = VCNT_W'(V_FP - 1);

  // Phase table:
  //   PH_SYNC        | sync lines, VSYNC at SYNC_POL
  //   PH_BACK_PORCH  | blank lines after sync
  //   PH_ACTIVE      | visible lines, scaled-row counting enabled
  //   PH_FRONT_PORCH | blank lines before the next sync
  phase_e            phase, phase_nxt;
  logic [VCNT_W-1:0] line_cnt, line_cnt_nxt;
  logic [VCNT_W-1:0] phase_last;
  logic              phase_done;
  logic [VCNT_W-1:0] ver_nxt;
  logic              vsync_nxt, v_active_nxt, frame_start_nxt;
  logic              sc_clear, sc_step;

  always_comb begin
    phase_last = SYNC_LAST;
    unique case (phase)
      PH_SYNC:        phase_last = SYNC_LAST;
      PH_BACK_PORCH:  phase_last = BP_LAST;
      PH_ACTIVE:      phase_last = ACTIVE_LAST;
      PH_FRONT_PORCH: phase_last = FP_LAST;
    endcase
  end

  assign phase_done = new_line && (line_cnt == phase_last);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase    <= PH_SYNC;
      line_cnt <= '0;
      ver_cnt  <= '0;
    end else begin
      phase    <= phase_nxt;
      line_cnt <= line_cnt_nxt;
      ver_cnt  <= ver_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    phase_nxt    = phase;
    line_cnt_nxt = line_cnt;
    ver_nxt      = ver_cnt;
    if (new_line) begin
      ver_nxt = (ver_cnt == VCNT_MAX) ? '0 : ver_cnt + 1'b1;
      if (phase_done) begin
        line_cnt_nxt = '0;
        unique case (phase)
          PH_SYNC:        phase_nxt = PH_BACK_PORCH;
          PH_BACK_PORCH:  phase_nxt = PH_ACTIVE;
          PH_ACTIVE:      phase_nxt = PH_FRONT_PORCH;
          PH_FRONT_PORCH: phase_nxt = PH_SYNC;
        endcase
      end else begin
        line_cnt_nxt = line_cnt + 1'b1;
      end
    end
  end

  // Output logic, evaluated on next-state values
  always_comb begin
    vsync_nxt       = (phase_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    v_active_nxt    = (phase_nxt == PH_ACTIVE);
    frame_start_nxt = new_line && (ver_cnt == VCNT_MAX);
    sc_clear        = phase_done && (phase == PH_BACK_PORCH);
    // The line that leaves ACTIVE must not open another row.
    sc_step         = new_line && (phase == PH_ACTIVE) && !phase_done;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      VSYNC       <= SYNC_POL;
      v_active    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      VSYNC       <= vsync_nxt;
      v_active    <= v_active_nxt;
      frame_start <= frame_start_nxt;
    end
  end

  scale_counter #(
    .SCALE (SCALE),
    .ROWS  (ROWS)
  ) u_scale_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (sc_clear),
    .step      (sc_step),
    .row       (scl_ver_cnt),
    .row_start (row_start)
  );

endmodule

// File: tb/tb_vertical_timing_engine.sv
// Directed bench for vertical_timing_engine: default timing, SCALE=7, and
// SYNC_POL=1 with a short sync/back porch, all driven by the same new_line.
module tb_vertical_timing_engine;

  logic clk = 1'b0;
  logic reset;
  logic new_line;

  always #5 clk = ~clk;

  // defaults: V_TOTAL 525, ROWS 96
  logic [9:0] ver_d;
  logic [6:0] scl_d;
  logic       vs_d, act_d, fs_d, rs_d;
  // SCALE=7: ROWS 69
  logic [9:0] ver_7;
  logic [6:0] scl_7;
  logic       vs_7, act_7, fs_7, rs_7;
  // SYNC_POL=1, V_SYNC=3, V_BP=1: V_TOTAL 494
  logic [8:0] ver_p;
  logic [6:0] scl_p;
  logic       vs_p, act_p, fs_p, rs_p;

  vertical_timing_engine dut (
    .clk(clk), .reset(reset), .new_line(new_line),
    .ver_cnt(ver_d), .scl_ver_cnt(scl_d), .VSYNC(vs_d),
    .v_active(act_d), .frame_start(fs_d), .row_start(rs_d)
  );

  vertical_timing_engine #(.SCALE(7), .V_ACTIVE(480)) dut7 (
    .clk(clk), .reset(reset), .new_line(new_line),
    .ver_cnt(ver_7), .scl_ver_cnt(scl_7), .VSYNC(vs_7),
    .v_active(act_7), .frame_start(fs_7), .row_start(rs_7)
  );

  vertical_timing_engine #(.SYNC_POL(1'b1), .V_SYNC(3), .V_BP(1)) dutp (
    .clk(clk), .reset(reset), .new_line(new_line),
    .ver_cnt(ver_p), .scl_ver_cnt(scl_p), .VSYNC(vs_p),
    .v_active(act_p), .frame_start(fs_p), .row_start(rs_p)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse();
    @(negedge clk);
    new_line = 1'b1;
    @(negedge clk);
    new_line = 1'b0;
  endtask

  int L, Lp;
  bit a, ap;
  bit seen_d, seen_7, seen_p;
  int rs_cnt, rs7_cnt, fs_cnt, last7_lines;

  initial begin
    reset    = 1'b1;
    new_line = 1'b0;
    seen_d = 0; seen_7 = 0; seen_p = 0;
    rs_cnt = 0; rs7_cnt = 0; fs_cnt = 0; last7_lines = 0;

    // reset state
    @(negedge clk);
    chk("rst_ver_cnt", ver_d, 0);
    chk("rst_scl", scl_d, 0);
    chk("rst_vsync", vs_d, 0);
    chk("rst_v_active", act_d, 0);
    chk("rst_frame_start", fs_d, 0);
    chk("rst_row_start", rs_d, 0);
    chk("rst_vsync_pol1", vs_p, 1);
    @(negedge clk);
    reset = 1'b0;

    // one full default frame, spaced pulses
    for (int i = 1; i <= 525; i++) begin
      pulse();
      L  = i % 525;
      Lp = i % 494;
      a  = (L >= 35) && (L <= 514);
      ap = (Lp >= 4) && (Lp <= 483);

      chk("ver_cnt", ver_d, L);
      chk("vsync", vs_d, (L < 2) ? 0 : 1);
      chk("v_active", act_d, a);
      chk("frame_start", fs_d, (L == 0));
      chk("scl", scl_d, a ? (L - 35) / 5 : (seen_d ? 95 : 0));
      chk("row_start", rs_d, a && ((L - 35) % 5 == 0));
      if (a) seen_d = 1;
      if (rs_d === 1'b1) rs_cnt++;
      if (fs_d === 1'b1) fs_cnt++;

      chk("scl7", scl_7, a ? (L - 35) / 7 : (seen_7 ? 68 : 0));
      chk("row_start7", rs_7, a && ((L - 35) % 7 == 0));
      if (a) seen_7 = 1;
      if (rs_7 === 1'b1) rs7_cnt++;
      if (act_7 === 1'b1 && scl_7 == 7'd68) last7_lines++;

      chk("ver_cnt_p", ver_p, Lp);
      chk("vsync_p", vs_p, (Lp < 3) ? 1 : 0);
      chk("v_active_p", act_p, ap);
      chk("frame_start_p", fs_p, (Lp == 0));
      chk("scl_p", scl_p, ap ? (Lp - 4) / 5 : (seen_p ? 95 : 0));
      if (ap) seen_p = 1;
    end
    chk("row_start_count", rs_cnt, 96);
    chk("frame_start_count", fs_cnt, 1);
    chk("row_start_count7", rs7_cnt, 69);
    chk("last_row_lines7", last7_lines, 4);

    // asynchronous reset at line 200
    for (int i = 1; i <= 200; i++) pulse();
    chk("pre_reset_ver", ver_d, 200);
    #1 reset = 1'b1;
    #1;
    chk("async_ver_cnt", ver_d, 0);
    chk("async_scl", scl_d, 0);
    chk("async_vsync", vs_d, 0);
    chk("async_v_active", act_d, 0);
    chk("async_frame_start", fs_d, 0);
    chk("async_row_start", rs_d, 0);
    chk("async_vsync_p", vs_p, 1);
    chk("async_ver_p", ver_p, 0);
    @(negedge clk);
    reset = 1'b0;
    pulse();
    chk("after_reset_ver", ver_d, 1);
    chk("after_reset_fs", fs_d, 0);
    chk("after_reset_vsync", vs_d, 0);

    // new_line held high for 600 cycles
    #1 reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    new_line = 1'b1;
    for (int i = 0; i < 600; i++) begin
      L  = i % 525;
      Lp = i % 494;
      a  = (L >= 35) && (L <= 514);
      ap = (Lp >= 4) && (Lp <= 483);
      chk("b2b_ver_cnt", ver_d, L);
      chk("b2b_vsync", vs_d, (L < 2) ? 0 : 1);
      chk("b2b_v_active", act_d, a);
      chk("b2b_frame_start", fs_d, (L == 0) && (i > 0));
      chk("b2b_scl", scl_d, a ? (L - 35) / 5 : ((i >= 35) ? 95 : 0));
      chk("b2b_ver_p", ver_p, Lp);
      chk("b2b_vsync_p", vs_p, (Lp < 3) ? 1 : 0);
      chk("b2b_v_active_p", act_p, ap);
      @(negedge clk);
    end
    new_line = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
